addr_seq: RTL and testbench

Addressing-mode sequencer for the MOSby core. It steps the address buffer through the bus cycles of one operand access: operand fetch from PC, optional indexing, then the effective zero-page, absolute or stack access. Each cycle it drives the buffer's `access_type`, the effective address bytes, the PC/SP adjust strobes and the write enable. The instruction decoder hands it one addressing mode per request over a start/done handshake.

---
 rtl/mos_pkg.sv | 42 ++++
 rtl/idx_add.sv | 12 +
 rtl/addr_seq.sv | 189 ++++++++++++++++++
 tb/tb_addr_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mos_pkg.sv
// Shared constants for the MOSby address path: access types,
// addressing-mode codes and the addr_seq FSM state encoding.
package mos_pkg;

  typedef enum logic [1:0] {
    AT_ZERO  = 2'd0,
    AT_STACK = 2'd1,
    AT_PC    = 2'd2,
    AT_ABSOL = 2'd3
  } access_e;

  typedef enum logic [3:0] {
    M_IMP  = 4'd0,
    M_IMM  = 4'd1,
    M_ZP   = 4'd2,
    M_ZPX  = 4'd3,
    M_ZPY  = 4'd4,
    M_ABS  = 4'd5,
    M_ABSX = 4'd6,
    M_ABSY = 4'd7,
    M_PUSH = 4'd8,
    M_PULL = 4'd9
  } mode_e;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_OPL  = 4'd1,
    S_OPH  = 4'd2,
    S_IDX  = 4'd3,
    S_FIX  = 4'd4,
    S_EFF  = 4'd5,
    S_SPI  = 4'd6,
    S_STK  = 4'd7,
    S_IMPD = 4'd8
  } state_e;

  // Unassigned mode codes behave as implied addressing.
  function automatic mode_e norm_mode(input logic [3:0] m);
    return (m > 4'd9) ? M_IMP : mode_e'(m);
  endfunction

endpackage

// File: rtl/idx_add.sv
// 8-bit index adder for the effective-address low byte.
// Returns the wrapped sum and the carry into the high byte.
module idx_add (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o,
  output logic       carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/addr_seq.sv
// Addressing-mode sequencer: walks one operand access per request.
// Build option ADDR_SEQ_PAGE_CROSS_EN: indexed-absolute reads skip FIX without carry.
module addr_seq
  import mos_pkg::*;
(
  input  logic       clk_1,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mode,
  input  logic       wr,
  input  logic [7:0] data_bus,
  input  logic [7:0] data_x,
  input  logic [7:0] data_y,
  output logic [1:0] access_type,
  output logic [7:0] ab_lo,
  output logic [7:0] ab_hi,
  output logic       pc_inc,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       mem_we,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic       wr_q, wr_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic       carry_q, carry_d;

  mode_e      req_m;
  logic [7:0] idx;
  logic [7:0] sum;
  logic       cry;
  access_e    at;
  logic       zp_mode;

  assign req_m = norm_mode(mode);
  assign zp_mode = (mode_q == M_ZP) || (mode_q == M_ZPX)
                || (mode_q == M_ZPY);

  // Index register selected by the latched mode.
  always_comb begin
    idx = 8'h00;
    unique case (mode_q)
      M_ZPX, M_ABSX: idx = data_x;
      M_ZPY, M_ABSY: idx = data_y;
      default:       idx = 8'h00;
    endcase
  end

  idx_add u_idx_add (
    .a_i     (lo_q),
    .b_i     (idx),
    .sum_o   (sum),
    .carry_o (cry)
  );

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_IMP;
      wr_q    <= 1'b0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
    end
  end

  // Next state and operand datapath.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wr_d    = wr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = req_m;
          wr_d   = wr;
          unique case (req_m)
            M_IMP:   state_d = S_IMPD;
            M_PUSH:  state_d = S_STK;
            M_PULL:  state_d = S_SPI;
            default: state_d = S_OPL;
          endcase
        end
      end
      S_OPL: begin
        lo_d = data_bus;
        unique case (mode_q)
          M_IMM:        state_d = S_IDLE;
          M_ZP:         state_d = S_EFF;
          M_ZPX, M_ZPY: state_d = S_IDX;
          default:      state_d = S_OPH;
        endcase
      end
      S_OPH: begin
        hi_d    = data_bus;
        lo_d    = sum;
        carry_d = cry;
        if (mode_q == M_ABS) begin
          state_d = S_EFF;
        end else begin
`ifdef ADDR_SEQ_PAGE_CROSS_EN
          state_d = (wr_q || cry) ? S_FIX : S_EFF;
`else
          state_d = S_FIX;
`endif
        end
      end
      S_IDX: begin
        lo_d    = sum;
        state_d = S_EFF;
      end
      S_FIX: begin
        hi_d    = hi_q + {7'd0, carry_q};
        state_d = S_EFF;
      end
      S_SPI:   state_d = S_STK;
      S_EFF,
      S_STK,
      S_IMPD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from the registered state.
  always_comb begin
    at     = AT_PC;
    ab_lo  = 8'h00;
    ab_hi  = 8'h00;
    pc_inc = 1'b0;
    sp_inc = 1'b0;
    sp_dec = 1'b0;
    mem_we = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      S_OPL: begin
        pc_inc = 1'b1;
        done   = (mode_q == M_IMM);
      end
      S_OPH: pc_inc = 1'b1;
      S_IDX: begin
        at    = AT_ZERO;
        ab_lo = lo_q;
      end
      S_FIX: begin
        at    = AT_ABSOL;
        ab_lo = lo_q;
        ab_hi = hi_q;
      end
      S_EFF: begin
        at     = zp_mode ? AT_ZERO : AT_ABSOL;
        ab_lo  = lo_q;
        ab_hi  = zp_mode ? 8'h00 : hi_q;
        mem_we = wr_q;
        done   = 1'b1;
      end
      S_SPI: begin
        at     = AT_STACK;
        sp_inc = 1'b1;
      end
      S_STK: begin
        at     = AT_STACK;
        sp_dec = (mode_q == M_PUSH);
        mem_we = (mode_q == M_PUSH);
        done   = 1'b1;
      end
      S_IMPD:  done = 1'b1;
      default: ;
    endcase
  end

  assign access_type = at;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_addr_seq.sv
// Self-checking bench for addr_seq: directed cases plus random
// sequences compared against a per-cycle behavioural model.
module tb_addr_seq;

  localparam logic [1:0] ZERO  = 2'd0;
  localparam logic [1:0] STACK = 2'd1;
  localparam logic [1:0] PC    = 2'd2;
  localparam logic [1:0] ABSOL = 2'd3;
  localparam logic [23:0] IDLE_V = {PC, 8'h00, 8'h00, 6'b0};

  logic       clk_1 = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mode;
  logic       wr;
  logic [7:0] data_bus;
  logic [7:0] data_x;
  logic [7:0] data_y;
  logic [1:0] access_type;
  logic [7:0] ab_lo;
  logic [7:0] ab_hi;
  logic       pc_inc;
  logic       sp_inc;
  logic       sp_dec;
  logic       mem_we;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  addr_seq dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .wr          (wr),
    .data_bus    (data_bus),
    .data_x      (data_x),
    .data_y      (data_y),
    .access_type (access_type),
    .ab_lo       (ab_lo),
    .ab_hi       (ab_hi),
    .pc_inc      (pc_inc),
    .sp_inc      (sp_inc),
    .sp_dec      (sp_dec),
    .mem_we      (mem_we),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_1 = ~clk_1;

  wire [23:0] obs = {access_type, ab_lo, ab_hi,
                     pc_inc, sp_inc, sp_dec, mem_we, busy, done};

  function automatic logic [23:0] pk(
    input logic [1:0] at, input logic [7:0] lo, input logic [7:0] hi,
    input logic pci, input logic spi, input logic spd,
    input logic we, input logic dn);
    return {at, lo, hi, pci, spi, spd, we, 1'b1, dn};
  endfunction

  task automatic check(input string tag, input logic [23:0] e);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
  endtask

  // Expected bus cycles of one access, from the mode's cycle recipe.
  function automatic void model(input int m, input bit w,
    input logic [7:0] b0, input logic [7:0] b1,
    input logic [7:0] x, input logic [7:0] y);
    logic [7:0]  ix;
    logic [8:0]  zs;
    logic [15:0] ea;
    bit          fix;
    exp_q.delete();
    if (m > 9) m = 0;
    ix = (m == 3 || m == 6) ? x : (m == 4 || m == 7) ? y : 8'h00;
    zs = {1'b0, b0} + {1'b0, ix};
    ea = {b1, b0} + {8'h00, ix};
    case (m)
      0: exp_q.push_back(pk(PC, 0, 0, 0, 0, 0, 0, 1));
      1: exp_q.push_back(pk(PC, 0, 0, 1, 0, 0, 0, 1));
      2: begin
        exp_q.push_back(pk(PC, 0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(pk(ZERO, b0, 0, 0, 0, 0, w, 1));
      end
      3, 4: begin
        exp_q.push_back(pk(PC, 0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(pk(ZERO, b0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(pk(ZERO, zs[7:0], 0, 0, 0, 0, w, 1));
      end
      5, 6, 7: begin
        exp_q.push_back(pk(PC, 0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(pk(PC, 0, 0, 1, 0, 0, 0, 0));
        if (m != 5) begin
`ifdef ADDR_SEQ_PAGE_CROSS_EN
          fix = w || zs[8];
`else
          fix = 1'b1;
`endif
          if (fix)
            exp_q.push_back(pk(ABSOL, zs[7:0], b1, 0, 0, 0, 0, 0));
        end
        exp_q.push_back(pk(ABSOL, ea[7:0], ea[15:8], 0, 0, 0, w, 1));
      end
      8: exp_q.push_back(pk(STACK, 0, 0, 0, 0, 1, 1, 1));
      default: begin
        exp_q.push_back(pk(STACK, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(pk(STACK, 0, 0, 0, 0, 0, 0, 1));
      end
    endcase
  endfunction

  // Issue one request from IDLE and check every cycle through done.
  task automatic seq(input int m, input bit w,
    input logic [7:0] b0, input logic [7:0] b1,
    input logic [7:0] x, input logic [7:0] y,
    input bit noise, input logic hs, input logic [3:0] hm,
    input string tag);
    model(m, w, b0, b1, x, y);
    start    = 1'b1;
    mode     = m[3:0];
    wr       = w;
    data_x   = x;
    data_y   = y;
    data_bus = 8'($urandom);
    @(negedge clk_1);
    check({tag, ":idle"}, IDLE_V);
    @(posedge clk_1); #1;
    foreach (exp_q[i]) begin
      data_bus = (i == 0) ? b0 : (i == 1) ? b1 : 8'($urandom);
      if (noise) begin
        start = 1'($urandom);
        mode  = 4'($urandom);
        wr    = 1'($urandom);
      end else begin
        start = hs;
        mode  = hm;
      end
      @(negedge clk_1);
      check($sformatf("%s:c%0d", tag, i + 1), exp_q[i]);
      @(posedge clk_1); #1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 4'd0;
    wr       = 1'b0;
    data_bus = 8'h00;
    data_x   = 8'h00;
    data_y   = 8'h00;
    repeat (3) @(posedge clk_1);
    @(negedge clk_1);
    check("reset", IDLE_V);
    @(posedge clk_1); #1;
    rst = 1'b0;

    seq(3, 0, 8'hFE, 8'h00, 8'h05, 8'h00, 0, 0, 0, "zpx_wrap");
    seq(6, 0, 8'hF0, 8'h12, 8'h20, 8'h00, 0, 0, 0, "absx_cross");
    seq(6, 0, 8'h10, 8'h12, 8'h20, 8'h00, 0, 0, 0, "absx_nocross");
    seq(7, 1, 8'hFF, 8'hFF, 8'h00, 8'h01, 0, 0, 0, "absy_wr_wrap");
    seq(9, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, "pull");
    seq(8, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, "push");
    seq(1, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 0, 0, "imm");
    seq(2, 1, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 0, "zp_wr");

    // start held high through ABS, then mode 13 runs as IMP
    seq(5, 0, 8'h34, 8'h12, 8'h00, 8'h00, 0, 1, 4'd13, "abs_hold");
    seq(13, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, "imp13");

    // reset mid-ABS in cycle 2
    start = 1'b1;
    mode  = 4'd5;
    wr    = 1'b1;
    @(negedge clk_1);
    check("rst_abs:idle", IDLE_V);
    @(posedge clk_1); #1;
    start    = 1'b0;
    data_bus = 8'h34;
    @(negedge clk_1);
    check("rst_abs:c1", pk(PC, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk_1); #1;
    data_bus = 8'h12;
    rst      = 1'b1;
    @(negedge clk_1);
    check("rst_abs:c2", pk(PC, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk_1); #1;
    rst = 1'b0;
    @(negedge clk_1);
    check("rst_abs:c3", IDLE_V);
    @(posedge clk_1); #1;
    @(negedge clk_1);
    check("rst_abs:c4", IDLE_V);
    @(posedge clk_1); #1;
    seq(2, 0, 8'h44, 8'h00, 8'h00, 8'h00, 0, 0, 0, "zp_after_rst");

    for (int n = 0; n < 200; n++) begin
      seq(int'($urandom_range(0, 15)), 1'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
          1, 0, 0, $sformatf("rnd%0d", n));
    end

    start = 1'b0;
    @(negedge clk_1);
    check("final_idle", IDLE_V);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
